fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 75 +++++++
 tb/tb_fetch_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch/decode sequencer driving PC, IM and datapath handshakes
module fetch_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] IR_op,
  input  logic [5:0] IR_funct,
  input  logic       zero,
  input  logic       ex_done,
  output logic       PC_ld,
  output logic       PC_inc,
  output logic       IM_cs,
  output logic       IM_rd,
  output logic       IR_ld,
  output logic [1:0] PC_sel,
  output logic       ex_start,
  output logic       link_wr,
  output logic       halted,
  output logic       err
);
  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_BRANCH, S_JUMP, S_JR, S_EXEC, S_HALT
  } state_t;
  state_t state, nxt, dec;
  logic [5:0] op_q;
  logic [4:0] cnt;
  logic timeout;
  assign timeout = cnt == 5'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (reset) state <= S_RESET;
    else state <= nxt;
  end
  always_comb begin
    dec = (IR_op == 6'h04 || IR_op == 6'h05) ? S_BRANCH :
          (IR_op == 6'h02 || IR_op == 6'h03) ? S_JUMP :
          (IR_op == 6'h00 && IR_funct == 6'h08) ? S_JR :
          (IR_op == 6'h00 && IR_funct == 6'h0D) ? S_HALT : S_EXEC;
    nxt = state;
    case (state)
      S_RESET:  nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = dec;
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_JR:     nxt = S_FETCH;
      S_EXEC:   nxt = ex_done ? S_FETCH : timeout ? S_HALT : S_EXEC;
      S_HALT:   nxt = S_HALT;
    endcase
  end
  // wait counter is held at 0 outside EXEC so every EXEC entry starts from 0
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      if (state == S_DECODE) op_q <= IR_op;
      cnt <= (state != S_EXEC) ? '0 : ex_done ? cnt : cnt + 5'd1;
      err <= err | (state == S_EXEC && nxt == S_HALT);
    end
  end
  always_comb begin
    PC_inc   = state == S_FETCH;
    IM_cs    = state == S_FETCH;
    IM_rd    = state == S_FETCH;
    IR_ld    = state == S_FETCH;
    PC_sel   = (state == S_JUMP) ? 2'b01 : (state == S_JR) ? 2'b11 : 2'b00;
    PC_ld    = state == S_JUMP || state == S_JR ||
               (state == S_BRANCH && ((op_q == 6'h05) ? !zero : zero));
    link_wr  = state == S_JUMP && op_q == 6'h03;
    ex_start = state == S_DECODE && nxt == S_EXEC;
    halted   = state == S_HALT;
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed plus randomized instruction streams checked against a per-instruction trace model
module tb_fetch_sequencer;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, ex_done = 1'b0;
  logic [5:0] IR_op = '0, IR_funct = '0;
  logic PC_ld, PC_inc, IM_cs, IM_rd, IR_ld, ex_start, link_wr, halted, err;
  logic [1:0] PC_sel;
  int checks = 0, failures = 0;
  localparam int TMO = 16;
  localparam logic [10:0] Z  = 11'b0;
  localparam logic [10:0] FE = 11'b0_1_1_1_1_00_0_0_0_0;
  fetch_sequencer #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .IR_op(IR_op), .IR_funct(IR_funct), .zero(zero),
    .ex_done(ex_done), .PC_ld(PC_ld), .PC_inc(PC_inc), .IM_cs(IM_cs), .IM_rd(IM_rd),
    .IR_ld(IR_ld), .PC_sel(PC_sel), .ex_start(ex_start), .link_wr(link_wr),
    .halted(halted), .err(err)
  );
  always #5 clk = ~clk;
  // bit order: PC_ld PC_inc IM_cs IM_rd IR_ld PC_sel[1:0] ex_start link_wr halted err
  function automatic logic [10:0] act(input logic ld, input logic [1:0] sel, input logic lw);
    return {ld, 4'b0, sel, 1'b0, lw, 2'b0};
  endfunction
  function automatic logic [10:0] hlt(input logic e);
    return {9'b0, 1'b1, e};
  endfunction
  task automatic cyc(input logic [10:0] exp, input logic z, input logic d, input string tag);
    logic [10:0] obs;
    @(negedge clk);
    zero = z;
    ex_done = d;
    #1;
    obs = {PC_ld, PC_inc, IM_cs, IM_rd, IR_ld, PC_sel, ex_start, link_wr, halted, err};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
    checks++;
    assert (!(PC_ld && PC_inc)) else begin
      failures++;
      $error("FAIL %s_ld_inc obs=%b exp=0", tag, PC_ld && PC_inc);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) cyc(Z, 1'($urandom), 1'($urandom), "reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    assert ({PC_ld, PC_inc, IM_cs, IM_rd, IR_ld, PC_sel, ex_start, link_wr, halted, err} === Z)
      else begin
        failures++;
        $error("FAIL release obs=%b exp=%b", {PC_ld, PC_inc, IM_cs, IM_rd, IR_ld, PC_sel,
               ex_start, link_wr, halted, err}, Z);
      end
  endtask
  // one instruction from FETCH onward; n = EXEC cycle on which ex_done rises (>TMO: never)
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n);
    bit br, jmp, jr, brk, stop;
    br  = op == 6'h04 || op == 6'h05;
    jmp = !br && (op == 6'h02 || op == 6'h03);
    jr  = !br && !jmp && op == 6'h00 && fn == 6'h08;
    brk = !br && !jmp && !jr && op == 6'h00 && fn == 6'h0D;
    stop = brk;
    IR_op = op;
    IR_funct = fn;
    cyc(FE, 1'($urandom), 1'($urandom), "fetch");
    cyc({7'b0, !(br || jmp || jr || brk), 3'b0}, 1'($urandom), 1'($urandom), "decode");
    if (br) cyc(act((op == 6'h04) ? z : !z, 2'b00, 1'b0), z, 1'($urandom), "branch");
    else if (jmp) cyc(act(1'b1, 2'b01, op == 6'h03), 1'($urandom), 1'($urandom), "jump");
    else if (jr) cyc(act(1'b1, 2'b11, 1'b0), 1'($urandom), 1'($urandom), "jr");
    else if (!brk) begin
      for (int k = 1; k <= TMO && !(k > n); k++) cyc(Z, 1'($urandom), k == n, "exec");
      stop = n > TMO;
    end
    if (stop) begin
      for (int k = 0; k < 3; k++) cyc(hlt(!brk), 1'($urandom), 1'($urandom), "halt");
      do_reset();
    end
  endtask
  initial begin
    int sel, n;
    logic [5:0] op, fn;
    do_reset();
    run_instr(6'h04, 6'h00, 1'b1, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0);
    run_instr(6'h05, 6'h11, 1'b0, 0);
    run_instr(6'h03, 6'h00, 1'b0, 0);
    run_instr(6'h02, 6'h00, 1'b0, 0);
    run_instr(6'h00, 6'h08, 1'b0, 0);
    run_instr(6'h00, 6'h20, 1'b0, 3);
    run_instr(6'h00, 6'h20, 1'b0, TMO);
    run_instr(6'h00, 6'h20, 1'b0, TMO + 1);
    run_instr(6'h00, 6'h0D, 1'b0, 0);
    for (int t = 0; t < 80; t++) begin
      sel = int'($urandom_range(0, 7));
      op = 6'($urandom);
      fn = 6'($urandom);
      op = (sel == 0) ? 6'h04 : (sel == 1) ? 6'h05 : (sel == 2) ? 6'h02 :
           (sel == 3) ? 6'h03 : (sel < 6) ? 6'h00 : op;
      fn = (sel == 4) ? ($urandom_range(0, 3) == 0 ? 6'h0D : 6'h08) : fn;
      n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TMO - 1, TMO + 2))
                                      : int'($urandom_range(1, 6));
      run_instr(op, fn, 1'($urandom), n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
